// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding and frame constants for the UART receiver
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead byte buffer between the receiver and the reader
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full buffer still accepts the push
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with 16x oversampling feeding a small byte buffer
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       frame_err,
  output logic       overflow
);

  localparam int SAMPLE_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic [PW-1:0]        presc;
  logic [TW-1:0]        tick_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 push;
  logic                 full;

  assign tick = (presc == PRESC_MAX);
  // the stop-bit sample cycle itself writes the byte into the buffer
  assign push = (state == STOP) && tick && (tick_cnt == TICK_LAST) && rx_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      presc     <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      frame_err <= 1'b0;
      overflow  <= push && full && !(rd_en && !empty);

      if (state == IDLE || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (!rx_sync) begin
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_sync ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == TICK_LAST) begin
              shift[bit_idx] <= rx_sync;
              bit_idx        <= bit_idx + 1'b1;
              if (bit_idx == BIT_LAST) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == TICK_LAST) begin
              if (rx_sync) begin
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_sync) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(shift),
    .pop  (rd_en),
    .rdata(rd_data),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx #(
    .CLK_FREQ(1600),
    .BAUD_RATE(100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overflow) ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(16);
    end
    rx = stop_bit;
    cyc(16);
  endtask

  task automatic pop1;
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    cyc(20);
  endtask

  task automatic test_single;
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    int lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 1; i <= 200 && lat == 0; i++) begin
          @(negedge clk);
          if (!empty) lat = i;
        end
      end
    join
    checks++; if (lat < 145 || lat > 165) begin failures++; $display("FAIL single_latency got=%0d exp=145..165", lat); end
    checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", rd_data); end
    checks++; if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin failures++; $display("FAIL single_pulses fe=%0d ov=%0d exp=0,0", fe_cnt - fe0, ov_cnt - ov0); end
    pop1();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty_after_pop got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q [4];
    int ov0;
    exp_q = '{8'h00, 8'hFF, 8'h3C, 8'h81};
    for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b1);
    ov0 = ov_cnt;
    send_frame(8'h55, 1'b1);
    cyc(2);
    checks++; if (ov_cnt - ov0 != 1) begin failures++; $display("FAIL b2b_overflow_pulses got=%0d exp=1", ov_cnt - ov0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== exp_q[i]) begin failures++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, rd_data, exp_q[i]); end
      pop1();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty_after got=%b exp=1", empty); end
  endtask

  task automatic test_glitch;
    int fe0 = fe_cnt;
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(40);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL glitch_no_byte got=%b exp=1", empty); end
    checks++; if (fe_cnt - fe0 != 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - fe0); end
    send_frame(8'hC3, 1'b1);
    checks++; if (empty !== 1'b0 || rd_data !== 8'hC3) begin failures++; $display("FAIL glitch_next_frame empty=%b data=%h exp=0,c3", empty, rd_data); end
    pop1();
  endtask

  task automatic test_frame_err;
    int fe0 = fe_cnt;
    send_frame(8'h12, 1'b0);
    cyc(24);
    rx = 1'b1;
    cyc(20);
    send_frame(8'h34, 1'b1);
    cyc(2);
    checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (rd_data !== 8'h34) begin failures++; $display("FAIL ferr_data got=%h exp=34", rd_data); end
    pop1();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ferr_only_one got=%b exp=1", empty); end
  endtask

  task automatic test_pop_empty;
    rd_en = 1'b1;
    cyc(3);
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pop_empty_flag got=%b exp=1", empty); end
    send_frame(8'h5A, 1'b1);
    checks++; if (empty !== 1'b0 || rd_data !== 8'h5A) begin failures++; $display("FAIL pop_empty_next empty=%b data=%h exp=0,5a", empty, rd_data); end
    pop1();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pop_empty_drain got=%b exp=1", empty); end
  endtask

  task automatic test_pop_on_full;
    logic [7:0] exp_q [4];
    int ov0;
    exp_q = '{8'h20, 8'h30, 8'h40, 8'h77};
    send_frame(8'h10, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(exp_q[i], 1'b1);
    ov0 = ov_cnt;
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    cyc(2);
    checks++; if (ov_cnt - ov0 != 0) begin failures++; $display("FAIL full_pop_overflow got=%0d exp=0", ov_cnt - ov0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (empty !== 1'b0 || rd_data !== exp_q[i]) begin failures++; $display("FAIL full_pop_order[%0d] empty=%b got=%h exp=%h", i, empty, rd_data, exp_q[i]); end
      pop1();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_pop_count got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int fe0;
    d = 8'h99;
    send_frame(8'hEE, 1'b1);
    fe0 = fe_cnt;
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      cyc(16);
    end
    rx = d[3];
    cyc(8);
    rst = 1'b1;
    cyc(2);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    rx = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(20);
    send_frame(8'h66, 1'b1);
    checks++; if (empty !== 1'b0 || rd_data !== 8'h66) begin failures++; $display("FAIL midrst_next empty=%b data=%h exp=0,66", empty, rd_data); end
    pop1();
    checks++; if (empty !== 1'b1 || fe_cnt - fe0 != 0) begin failures++; $display("FAIL midrst_only_one empty=%b fe=%0d exp=1,0", empty, fe_cnt - fe0); end
  endtask

  initial begin
    cyc(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_pop_empty();
    test_pop_on_full();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 CLK_FREQ, 100000000, system clock frequency in Hz.
REQ-002 BAUD_RATE, 115200, serial bit rate; SAMPLE_DIV = CLK_FREQ/(BAUD_RATE*16), integer, >= 1.
REQ-003 FIFO_DEPTH, 4, received-byte buffer depth, power of two, >= 2.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first (driven by CPU Tx).
REQ-007 rd_en  input  1  pop head byte when high and empty low.
REQ-008 rd_data  output  8  head byte of buffer (show-ahead), valid while empty low.
REQ-009 empty  output  1  buffer holds no bytes.
REQ-010 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 overflow  output  1  one-cycle pulse when a good byte is dropped because buffer full.

Function
REQ-012 rx passes a 2-flop synchronizer (both flops reset to 1) before any use; synchronizer adds 2 cycles of latency.
REQ-013 Prescaler counts 0..SAMPLE_DIV-1, emitting a 1-cycle sample tick at wrap; tick count per bit = 16.
REQ-014 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: on synchronized rx = 0, reset prescaler and tick counter, go to START.
REQ-016 START: at 8th tick re-sample; rx = 0 -> DATA with bit index 0; rx = 1 -> glitch, back to IDLE, nothing reported.
REQ-017 DATA: every 16 ticks sample rx into shift register bit[index], index 0..7; after bit 7 go to STOP.
REQ-018 STOP: after 16 ticks sample; rx = 1 -> push byte, IDLE; rx = 0 -> frame_err pulse, discard byte, WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until synchronized rx = 1, then IDLE (break condition never yields bytes).
REQ-020 Push occurs on the cycle of the stop sample; empty falls the following cycle; rd_data valid the same cycle as empty falls.
REQ-021 Pop with empty high is ignored; pointers unchanged.
REQ-022 Push when full and no pop in same cycle: byte dropped, overflow pulses, contents unchanged.
REQ-023 Simultaneous push and pop when full: both succeed, count unchanged, no overflow.
REQ-024 Simultaneous push and pop when empty: push succeeds, empty falls next cycle.
REQ-025 Pointers are log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 On rst: FSM IDLE, prescaler/tick/index 0, shift register 0, synchronizer 1s, FIFO pointers and count 0, empty = 1, rd_data = 0, frame_err = 0, overflow = 0.
REQ-027 rst mid-frame abandons the partial byte; next frame is received correctly once rx has been high for >= 1 bit time.

Structure
REQ-028 Shared package holds state enum, DATA_BITS = 8, OVERSAMPLE = 16.
REQ-029 Buffer is one sub-module, uart_rx_fifo (push/pop/full/empty/count); remainder is flat.

Verification (CLK_FREQ = 1600, BAUD_RATE = 100 -> SAMPLE_DIV = 1, 16 clocks/bit)
REQ-030 Send 0xA5 with valid stop -> empty falls ~ 150 clocks after start edge, rd_data = 0xA5, no pulses; rd_en one cycle -> empty = 1.
REQ-031 Send 0x00, 0xFF, 0x3C, 0x81 back-to-back without reading -> four bytes popped in that order; fifth 0x55 -> overflow pulses once, head still 0x00.
REQ-032 Hold rx low 4 clocks then high -> no byte, no frame_err, FSM IDLE.
REQ-033 Send 0x12 with stop bit 0, hold rx low 40 clocks, then send 0x34 -> frame_err pulses once, only 0x34 buffered.
REQ-034 Buffer full, issue rd_en on stop-sample cycle of 0x77 -> no overflow, 0x77 last in order, count stays 4.
REQ-035 Assert rst during DATA bit 3 of 0x99, then send 0x66 -> only 0x66 received, empty = 1 during rst.
